dag_modulo_unit: RTL and testbench

- Parametrised data-address generator for the DSP DAG.
- Holds NREG sets of index (I), modify (M) and length (L) registers.
- Issues one address per request and post-modifies (or pre-modifies) the selected I with circular-buffer (modulo) arithmetic.
- Adds registered output, bit-reversed addressing, a sticky wrap status and a register read-back port to the combinational 14-bit modulo datapath.

---
 rtl/dag_pkg.sv | 10 +
 rtl/dag_modulo_core.sv | 52 +++++
 rtl/dag_modulo_unit.sv | 98 +++++++++
 tb/tb_dag_modulo_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dag_pkg.sv
// Shared constants for the data-address generator: register-file selects and default width.
package dag_pkg;

  localparam int DEF_AW = 14;

  localparam logic [1:0] SEL_I = 2'd0;
  localparam logic [1:0] SEL_M = 2'd1;
  localparam logic [1:0] SEL_L = 2'd2;

endpackage

// File: rtl/dag_modulo_core.sv
// Combinational circular-buffer update: next index from I, M, L with a single modulo correction.
module dag_modulo_core
  import dag_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic [AW-1:0] i,
  input  logic [AW-1:0] m,
  input  logic [AW-1:0] l,
  output logic [AW-1:0] ni,
  output logic          wrap
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  // Smear the top set bit downwards: gives a mask of the low k bits, k = bit-width of v.
  function automatic logic [AW-1:0] smear(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r[AW-1] = v[AW-1];
    for (int j = AW - 2; j >= 0; j--) r[j] = r[j+1] | v[j];
    return r;
  endfunction

  logic        [AW-1:0] mask;
  logic signed [AW:0]   o_s;
  logic signed [AW:0]   m_s;
  logic signed [AW:0]   l_s;
  logic signed [AW:0]   n;
  logic signed [AW:0]   n_fix;

  always_comb begin
    mask  = smear(l - ONE);
    o_s   = {1'b0, i & mask};
    m_s   = {m[AW-1], m};
    l_s   = {1'b0, l};
    n     = o_s + m_s;
    n_fix = n;
    wrap  = 1'b0;
    ni    = i + m;
    if (l != '0) begin
      if (!m[AW-1] && (n >= l_s)) begin
        n_fix = n - l_s;
        wrap  = 1'b1;
      end else if (m[AW-1] && (n < 0)) begin
        n_fix = n + l_s;
        wrap  = 1'b1;
      end
      ni = (i & ~mask) | n_fix[AW-1:0];
    end
  end

endmodule

// File: rtl/dag_modulo_unit.sv
// Data-address generator: I/M/L register sets, registered modulo address output, wrap status, read-back.
module dag_modulo_unit
  import dag_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int NREG = 4,
  parameter int IW   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [1:0]    wr_sel,
  input  logic [IW-1:0] wr_idx,
  input  logic [AW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [1:0]    rd_sel,
  input  logic [IW-1:0] rd_idx,
  output logic [AW-1:0] rd_data,
  input  logic          ag_valid,
  input  logic [IW-1:0] ag_idx,
  input  logic [IW-1:0] ag_midx,
  input  logic          ag_premod,
  input  logic          ag_brev,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  output logic          wrap,
  output logic          wrap_sticky,
  input  logic          wrap_clr
);

  function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
    return r;
  endfunction

  logic [AW-1:0] i_reg [NREG];
  logic [AW-1:0] m_reg [NREG];
  logic [AW-1:0] l_reg [NREG];

  logic [AW-1:0] core_ni;
  logic          core_wrap;
  logic [AW-1:0] sel_addr;
  logic [AW-1:0] rd_mux;

  dag_modulo_core #(.AW(AW)) u_core (
    .i    (i_reg[ag_idx]),
    .m    (m_reg[ag_midx]),
    .l    (l_reg[ag_idx]),
    .ni   (core_ni),
    .wrap (core_wrap)
  );

  always_comb begin
    sel_addr = ag_premod ? core_ni : i_reg[ag_idx];
    rd_mux   = '0;
    case (rd_sel)
      SEL_I:   rd_mux = i_reg[rd_idx];
      SEL_M:   rd_mux = m_reg[rd_idx];
      SEL_L:   rd_mux = l_reg[rd_idx];
      default: rd_mux = '0;
    endcase
  end

  // Request stage -> registered address/status; a register write to the same I lands last and wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        i_reg[r] <= '0;
        m_reg[r] <= '0;
        l_reg[r] <= '0;
      end
      addr_out    <= '0;
      addr_valid  <= 1'b0;
      wrap        <= 1'b0;
      wrap_sticky <= 1'b0;
      rd_data     <= '0;
    end else begin
      addr_valid  <= ag_valid;
      wrap_sticky <= (wrap_sticky & ~wrap_clr) | (ag_valid & core_wrap);
      if (ag_valid) begin
        i_reg[ag_idx] <= core_ni;
        addr_out      <= ag_brev ? bit_rev(sel_addr) : sel_addr;
        wrap          <= core_wrap;
      end
      if (wr_en) begin
        case (wr_sel)
          SEL_I:   i_reg[wr_idx] <= wr_data;
          SEL_M:   m_reg[wr_idx] <= wr_data;
          SEL_L:   l_reg[wr_idx] <= wr_data;
          default: ;
        endcase
      end
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_dag_modulo_unit.sv
// Self-checking bench for dag_modulo_unit: directed plan plus randomized traffic against an arithmetic model.
module tb_dag_modulo_unit;

  localparam int AW   = 14;
  localparam int NREG = 4;
  localparam int IW   = 2;
  localparam int AMSK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_sel = '0;
  logic [IW-1:0] wr_idx = '0;
  logic [AW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [1:0]    rd_sel = '0;
  logic [IW-1:0] rd_idx = '0;
  logic [AW-1:0] rd_data;
  logic          ag_valid = 1'b0;
  logic [IW-1:0] ag_idx = '0;
  logic [IW-1:0] ag_midx = '0;
  logic          ag_premod = 1'b0;
  logic          ag_brev = 1'b0;
  logic [AW-1:0] addr_out;
  logic          addr_valid;
  logic          wrap;
  logic          wrap_sticky;
  logic          wrap_clr = 1'b0;

  dag_modulo_unit #(.AW(AW), .NREG(NREG), .IW(IW)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_idx(rd_idx), .rd_data(rd_data),
    .ag_valid(ag_valid), .ag_idx(ag_idx), .ag_midx(ag_midx),
    .ag_premod(ag_premod), .ag_brev(ag_brev),
    .addr_out(addr_out), .addr_valid(addr_valid),
    .wrap(wrap), .wrap_sticky(wrap_sticky), .wrap_clr(wrap_clr)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  int mi [NREG];
  int mm [NREG];
  int ml [NREG];
  int e_addr = 0, e_wrap = 0, e_sticky = 0, e_rd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int brev14(input int v);
    int r = 0;
    for (int b = 0; b < AW; b++) if (((v >> b) & 1) != 0) r |= 1 << (AW - 1 - b);
    return r;
  endfunction

  // Circular-buffer rule computed with plain integer arithmetic.
  task automatic ref_mod(input int i, input int m_raw, input int l, output int ni, output int w);
    int m, k, base, o, n;
    m = (m_raw >= (1 << (AW - 1))) ? m_raw - (1 << AW) : m_raw;
    w = 0;
    if (l == 0) begin
      ni = (i + m) & AMSK;
    end else begin
      k = 0;
      while ((1 << k) < l) k++;
      base = i & ~((1 << k) - 1) & AMSK;
      o = i & ((1 << k) - 1);
      n = o + m;
      if (m >= 0 && n >= l) begin n = n - l; w = 1; end
      else if (m < 0 && n < 0) begin n = n + l; w = 1; end
      ni = base | (n & AMSK);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin mi[r] = 0; mm[r] = 0; ml[r] = 0; end
    e_addr = 0; e_wrap = 0; e_sticky = 0; e_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int sel, input int idx, input int data);
    wr_en = 1'b1; wr_sel = 2'(sel); wr_idx = IW'(idx); wr_data = AW'(data);
    tick();
    wr_en = 1'b0;
    case (sel)
      0: mi[idx] = data & AMSK;
      1: mm[idx] = data & AMSK;
      2: ml[idx] = data & AMSK;
      default: ;
    endcase
  endtask

  task automatic rd(input int sel, input int idx, input string tag);
    rd_en = 1'b1; rd_sel = 2'(sel); rd_idx = IW'(idx);
    tick();
    rd_en = 1'b0;
    case (sel)
      0: e_rd = mi[idx];
      1: e_rd = mm[idx];
      2: e_rd = ml[idx];
      default: e_rd = 0;
    endcase
    check(tag, 32'(rd_data), 32'(e_rd));
  endtask

  task automatic req(input int idx, input int midx, input int pre, input int brev, input string tag);
    int ni, w, exp;
    ref_mod(mi[idx], mm[midx], ml[idx], ni, w);
    exp = (pre != 0) ? ni : mi[idx];
    if (brev != 0) exp = brev14(exp);
    ag_valid = 1'b1; ag_idx = IW'(idx); ag_midx = IW'(midx);
    ag_premod = pre[0]; ag_brev = brev[0];
    tick();
    ag_valid = 1'b0;
    mi[idx] = ni;
    e_addr = exp; e_wrap = w;
    e_sticky = ((e_sticky != 0) && !wrap_clr) || (w != 0) ? 1 : 0;
    check({tag, "_addr"}, 32'(addr_out), 32'(e_addr));
    check({tag, "_wrap"}, 32'(wrap), 32'(e_wrap));
    check({tag, "_vld"}, 32'(addr_valid), 32'd1);
    check({tag, "_sticky"}, 32'(wrap_sticky), 32'(e_sticky));
  endtask

  task automatic idle(input string tag);
    ag_valid = 1'b0;
    tick();
    e_sticky = ((e_sticky != 0) && !wrap_clr) ? 1 : 0;
    check({tag, "_vld"}, 32'(addr_valid), 32'd0);
    check({tag, "_addr_hold"}, 32'(addr_out), 32'(e_addr));
    check({tag, "_wrap_hold"}, 32'(wrap), 32'(e_wrap));
    check({tag, "_sticky"}, 32'(wrap_sticky), 32'(e_sticky));
    check({tag, "_rd_hold"}, 32'(rd_data), 32'(e_rd));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, data, op, m;
    model_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_vld", 32'(addr_valid), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_sticky", 32'(wrap_sticky), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    rd(0, 0, "rst_I0"); rd(1, 0, "rst_M0"); rd(2, 0, "rst_L0");

    // Linear stepping, back-to-back requests
    wr(2, 0, 0); wr(0, 0, 'h10); wr(1, 0, 3);
    req(0, 0, 0, 0, "lin0"); check("lin0_lit", 32'(addr_out), 32'h10);
    req(0, 0, 0, 0, "lin1"); check("lin1_lit", 32'(addr_out), 32'h13);
    req(0, 0, 0, 0, "lin2"); check("lin2_lit", 32'(addr_out), 32'h16);
    idle("lin_idle");
    rd(0, 0, "lin_I0"); check("lin_I0_lit", 32'(rd_data), 32'h19);

    // Circular positive, then pre-modify
    wr(2, 0, 10); wr(0, 0, 'h108);
    req(0, 0, 0, 0, "cpos"); check("cpos_wrap_lit", 32'(wrap), 32'd1);
    rd(0, 0, "cpos_I0"); check("cpos_I0_lit", 32'(rd_data), 32'h101);
    req(0, 0, 1, 0, "cpre"); check("cpre_lit", 32'(addr_out), 32'h104);

    // Circular negative and power-of-two length
    wr(1, 1, 'h3FFD); wr(0, 0, 'h101);
    req(0, 1, 0, 0, "cneg");
    rd(0, 0, "cneg_I0"); check("cneg_I0_lit", 32'(rd_data), 32'h108);
    wr(2, 2, 8); wr(0, 2, 'h46); wr(1, 2, 2);
    req(2, 2, 0, 0, "cpow");
    rd(0, 2, "cpow_I2"); check("cpow_I2_lit", 32'(rd_data), 32'h40);

    // Bit reverse and sticky status
    wr(0, 0, 1); wr(2, 0, 0);
    req(0, 0, 0, 1, "brev"); check("brev_lit", 32'(addr_out), 32'h2000);
    idle("stk_set"); check("stk_set_lit", 32'(wrap_sticky), 32'd1);
    wrap_clr = 1'b1;
    idle("stk_clr"); check("stk_clr_lit", 32'(wrap_sticky), 32'd0);
    wr(0, 2, 'h46);
    wrap_clr = 1'b1;
    req(2, 2, 0, 0, "stk_race"); check("stk_race_lit", 32'(wrap_sticky), 32'd1);
    wrap_clr = 1'b0;

    // Read-during-write returns old value; select 3 ignored / reads zero
    rd_en = 1'b1; rd_sel = 2'd1; rd_idx = 2'd3;
    wr_en = 1'b1; wr_sel = 2'd1; wr_idx = 2'd3; wr_data = 14'h55;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    e_rd = mm[3];
    check("rdw_old", 32'(rd_data), 32'(e_rd));
    mm[3] = 'h55;
    idle("rdw_idle");
    rd(1, 3, "rdw_new");
    wr(3, 1, 'h1234);
    rd(3, 1, "sel3_rd");
    rd(0, 1, "sel3_I1"); rd(1, 1, "sel3_M1"); rd(2, 1, "sel3_L1");

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 5);
      if (op == 0) begin
        sel = $urandom_range(0, 3);
        if (sel == 1) begin
          m = $urandom_range(0, 128) - 64;
          data = m & AMSK;
        end else if (sel == 2) data = $urandom_range(0, 64);
        else data = $urandom_range(0, AMSK);
        wr(sel, $urandom_range(0, NREG - 1), data);
      end else if (op == 1) begin
        rd($urandom_range(0, 3), $urandom_range(0, NREG - 1), "rnd_rd");
      end else if (op == 5) begin
        wrap_clr = ($urandom_range(0, 1) == 1);
        idle("rnd_idle");
        wrap_clr = 1'b0;
      end else begin
        wrap_clr = ($urandom_range(0, 3) == 0);
        req($urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
            $urandom_range(0, 1), $urandom_range(0, 1), "rnd_req");
        wrap_clr = 1'b0;
      end
    end

    // Write/request collision on I0, then reset with a request in flight
    wr(2, 0, 0); wr(1, 0, 1); wr(0, 0, 'h10);
    ag_valid = 1'b1; ag_idx = 2'd0; ag_midx = 2'd0; ag_premod = 1'b0; ag_brev = 1'b0;
    wr_en = 1'b1; wr_sel = 2'd0; wr_idx = 2'd0; wr_data = 14'h200;
    tick();
    wr_en = 1'b0;
    check("col_addr", 32'(addr_out), 32'h10);
    check("col_vld", 32'(addr_valid), 32'd1);
    mi[0] = 'h200;
    reset = 1'b1;
    tick();
    reset = 1'b0; ag_valid = 1'b0;
    model_reset();
    check("mrst_vld", 32'(addr_valid), 32'd0);
    check("mrst_addr", 32'(addr_out), 32'd0);
    check("mrst_sticky", 32'(wrap_sticky), 32'd0);
    rd(0, 0, "mrst_I0");
    idle("post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
